// File: rtl/ram_pkg.sv
// Shared encodings and helpers for the simple-dual-port RAM.
// Holds RDW policy codes, clear-FSM states and byte parity.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  function automatic logic byte_parity(
    input logic [7:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/ram_sdp_init_if.sv
// Write/read/init port bundle for ram_sdp_init.
// Master drives requests; slave returns read data and status.
interface ram_sdp_init_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  localparam int NBYTES = DWIDTH / 8;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [NBYTES-1:0] wr_be;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              init_req;
  logic              init_busy;
  logic              parity_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr, init_req,
    input  rd_data, rd_valid,
    input  init_busy, parity_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en, rd_addr, init_req,
    output rd_data, rd_valid,
    output init_busy, parity_err
  );

endinterface

// File: rtl/ram_init_ctrl.sv
// Clear engine: sweeps every address writing INIT_VALUE after
// reset or on init_req, and flags the array busy meanwhile.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int              AWIDTH     = 3,
  parameter int              DWIDTH     = 32,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_busy,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr,
  output logic [DWIDTH-1:0] clr_data
);

  clr_state_e        state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign init_busy = busy_q;
  assign clr_we    = (state_q == ST_CLEAR);
  assign clr_addr  = cnt_q;
  assign clr_data  = INIT_VALUE;

endmodule

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte enables, RDW policy, optional
// output register and self-clear. Optional: RAM_PARITY_EN.
module ram_sdp_init
  import ram_pkg::*;
#(
  parameter int                AWIDTH     = 3,
  parameter int                DWIDTH     = 32,
  parameter int                OUT_REG    = 0,
  parameter int                RDW_MODE   = RDW_OLD,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input logic           clock,
  input logic           reset,
  ram_sdp_init_if.slave bus
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic [DWIDTH-1:0] clr_data;

  ram_init_ctrl #(
    .AWIDTH     (AWIDTH),
    .DWIDTH     (DWIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .init_req  (bus.init_req),
    .init_busy (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data)
  );

  logic [NBYTES-1:0] mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = '0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (reset) begin
      mem_we = '0;
    end else if (clr_we) begin
      mem_we    = '1;
      mem_waddr = clr_addr;
      mem_wdata = clr_data;
    end else if (bus.wr_en) begin
      mem_we = bus.wr_be;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we[i])
        mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  logic              rd_fire;
  logic              coll;
  logic [NBYTES-1:0] byp;
  logic [DWIDTH-1:0] old_word;
  logic [DWIDTH-1:0] rd_word;
  logic              perr;

  // Write-first bypass only touches the bytes being written.
  always_comb begin
    rd_fire  = bus.rd_en && !busy;
    coll     = (RDW_MODE == RDW_NEW) && bus.wr_en && !busy
               && (bus.wr_addr == bus.rd_addr);
    old_word = mem[bus.rd_addr];
    rd_word  = old_word;
    byp      = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byp[i] = coll && bus.wr_be[i];
      if (byp[i])
        rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

`ifdef RAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we[i])
        par_mem[mem_waddr][i] <= byte_parity(mem_wdata[8*i +: 8]);
    end
  end

  // Bypassed bytes carry fresh data, so only stored bytes are checked.
  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (!byp[i] && (byte_parity(old_word[8*i +: 8])
                      != par_mem[bus.rd_addr][i]))
        perr = 1'b1;
    end
  end
`else
  assign perr = 1'b0;
`endif

  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              perr_q, perr_d;

  always_comb begin
    rd_data_d  = rd_fire ? rd_word : rd_data_q;
    rd_valid_d = rd_fire;
    perr_d     = rd_fire && perr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      perr_q     <= perr_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DWIDTH-1:0] o_data_q, o_data_d;
      logic              o_valid_q, o_valid_d;
      logic              o_perr_q, o_perr_d;

      always_comb begin
        o_data_d  = rd_valid_q ? rd_data_q : o_data_q;
        o_valid_d = rd_valid_q;
        o_perr_d  = perr_q;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          o_data_q  <= '0;
          o_valid_q <= 1'b0;
          o_perr_q  <= 1'b0;
        end else begin
          o_data_q  <= o_data_d;
          o_valid_q <= o_valid_d;
          o_perr_q  <= o_perr_d;
        end
      end

      assign bus.rd_data    = o_data_q;
      assign bus.rd_valid   = o_valid_q;
      assign bus.parity_err = o_perr_q;
    end else begin : g_noreg
      assign bus.rd_data    = rd_data_q;
      assign bus.rd_valid   = rd_valid_q;
      assign bus.parity_err = perr_q;
    end
  endgenerate

  assign bus.init_busy = busy;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: two instances (OUT_REG0/RDW_OLD and
// OUT_REG1/RDW_NEW) share stimulus; checked against an array model.
module tb_ram_sdp_init;

  localparam int          AW   = 3;
  localparam int          DW   = 32;
  localparam int          DEP  = 1 << AW;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic clk;
  logic rst;

  ram_sdp_init_if #(.AWIDTH(AW), .DWIDTH(DW)) b0 ();
  ram_sdp_init_if #(.AWIDTH(AW), .DWIDTH(DW)) b1 ();

  assign b1.wr_en    = b0.wr_en;
  assign b1.wr_addr  = b0.wr_addr;
  assign b1.wr_data  = b0.wr_data;
  assign b1.wr_be    = b0.wr_be;
  assign b1.rd_en    = b0.rd_en;
  assign b1.rd_addr  = b0.rd_addr;
  assign b1.init_req = b0.init_req;

  ram_sdp_init #(
    .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(0),
    .RDW_MODE(0), .INIT_VALUE(INIT)
  ) u0 (
    .clock(clk), .reset(rst), .bus(b0)
  );

  ram_sdp_init #(
    .AWIDTH(AW), .DWIDTH(DW), .OUT_REG(1),
    .RDW_MODE(1), .INIT_VALUE(INIT)
  ) u1 (
    .clock(clk), .reset(rst), .bus(b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_mem [DEP];
  logic        m_bad [DEP];
  logic        m_busy;
  int          m_cnt;
  logic        e0_v, e0_p, e1_v, e1_p, p1_v, p1_p;
  logic [31:0] e0_d, e1_d, p1_d;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    b0.wr_en    = 1'b0;
    b0.wr_addr  = '0;
    b0.wr_data  = '0;
    b0.wr_be    = '0;
    b0.rd_en    = 1'b0;
    b0.rd_addr  = '0;
    b0.init_req = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    e0_v = 0; e0_p = 0; e0_d = '0;
    e1_v = 0; e1_p = 0; e1_d = '0;
    p1_v = 0; p1_p = 0; p1_d = '0;
  endtask

  // Advance one clock: predict with the model, then compare both DUTs.
  task automatic step();
    logic        fire, coll, pe0, pe1;
    logic [31:0] old_w, mrg;
    if (rst) begin
      model_reset();
    end else begin
      fire  = b0.rd_en && !m_busy;
      coll  = b0.wr_en && !m_busy && (b0.wr_addr == b0.rd_addr);
      old_w = m_mem[b0.rd_addr];
      mrg   = old_w;
      if (coll)
        for (int i = 0; i < 4; i++)
          if (b0.wr_be[i]) mrg[8*i +: 8] = b0.wr_data[8*i +: 8];
      pe0 = m_bad[b0.rd_addr];
      pe1 = pe0 && !(coll && b0.wr_be[0]);
      e1_v = p1_v;
      e1_p = p1_v && p1_p;
      if (p1_v) e1_d = p1_d;
      p1_v = fire;
      p1_p = fire && pe1;
      if (fire) p1_d = mrg;
      e0_v = fire;
      e0_p = fire && pe0;
      if (fire) e0_d = old_w;
      if (m_busy) begin
        m_mem[m_cnt] = INIT;
        m_bad[m_cnt] = 1'b0;
        if (m_cnt == DEP - 1) m_busy = 1'b0;
        m_cnt = (m_cnt + 1) % DEP;
      end else begin
        if (b0.wr_en) begin
          for (int i = 0; i < 4; i++)
            if (b0.wr_be[i])
              m_mem[b0.wr_addr][8*i +: 8] = b0.wr_data[8*i +: 8];
          if (b0.wr_be[0]) m_bad[b0.wr_addr] = 1'b0;
        end
        if (b0.init_req) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("busy0",  32'(b0.init_busy),  32'(m_busy));
    chk("busy1",  32'(b1.init_busy),  32'(m_busy));
    chk("valid0", 32'(b0.rd_valid),   32'(e0_v));
    chk("valid1", 32'(b1.rd_valid),   32'(e1_v));
    chk("data0",  b0.rd_data,         e0_d);
    chk("data1",  b1.rd_data,         e1_d);
    chk("perr0",  32'(b0.parity_err), 32'(e0_p));
    chk("perr1",  32'(b1.parity_err), 32'(e1_p));
  endtask

  task automatic wait_clear(input string nm);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!b0.init_busy) begin
        k = i;
        break;
      end
    end
    chk(nm, k, 8);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [2:0]  ra;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    input logic we, input logic [2:0] wa, input logic [31:0] wd,
    input logic [3:0] be, input logic re, input logic [2:0] ra,
    input logic v0, input logic [31:0] d0,
    input logic v1, input logic [31:0] d1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.re = re; v.ra = ra;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    return v;
  endfunction

  initial begin
    for (int a = 0; a < DEP; a++) begin
      m_mem[a] = 'x;
      m_bad[a] = 1'b0;
    end

    tbl[0]  = mk(0, 0, 0, 0, 1, 0, 1, INIT, 0, 0);
    for (int a = 1; a < 8; a++)
      tbl[a] = mk(0, 0, 0, 0, 1, 3'(a), 1, INIT, 1, INIT);
    tbl[8]  = mk(1, 2, 32'h11223344, 4'hF, 0, 0, 0, 0, 1, INIT);
    tbl[9]  = mk(1, 2, 32'hFFFFFFFF, 4'b0101, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 2, 1, 32'h11FF33FF, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 1, INIT, 1, 32'h11FF33FF);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 1, INIT, 1, INIT);
    tbl[13] = mk(0, 0, 0, 0, 1, 2, 1, 32'h11FF33FF, 1, INIT);
    tbl[14] = mk(1, 5, 32'h0, 4'hF, 0, 0, 0, 0, 1, 32'h11FF33FF);
    tbl[15] = mk(1, 5, 32'hDEADBEEF, 4'b1100, 1, 5, 1, 32'h0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 5, 1, 32'hDEAD0000, 1, 32'hDEAD0000);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000);

    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_data0",  b0.rd_data, 32'h0);
    chk("rst_valid1", 32'(b1.rd_valid), 32'h0);
    chk("rst_busy0",  32'(b0.init_busy), 32'h1);
    step();
    step();
    rst = 1'b0;
    wait_clear("clear_len");

    foreach (tbl[n]) begin
      b0.wr_en   = tbl[n].we;
      b0.wr_addr = tbl[n].wa;
      b0.wr_data = tbl[n].wd;
      b0.wr_be   = tbl[n].be;
      b0.rd_en   = tbl[n].re;
      b0.rd_addr = tbl[n].ra;
      step();
      chk($sformatf("tbl%0d_v0", n), 32'(b0.rd_valid), 32'(tbl[n].v0));
      chk($sformatf("tbl%0d_v1", n), 32'(b1.rd_valid), 32'(tbl[n].v1));
      if (tbl[n].v0) chk($sformatf("tbl%0d_d0", n), b0.rd_data, tbl[n].d0);
      if (tbl[n].v1) chk($sformatf("tbl%0d_d1", n), b1.rd_data, tbl[n].d1);
    end
    idle();

    for (int c = 0; c < 400; c++) begin
      b0.wr_en    = ($urandom_range(0, 1) == 1);
      b0.wr_addr  = 3'($urandom_range(0, DEP - 1));
      b0.wr_data  = $urandom;
      b0.wr_be    = 4'($urandom_range(0, 15));
      b0.rd_en    = ($urandom_range(0, 2) != 0);
      b0.rd_addr  = ($urandom_range(0, 3) == 0) ? b0.wr_addr
                                                : 3'($urandom_range(0, DEP - 1));
      b0.init_req = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();

    for (int i = 0; i < 20 && m_busy; i++) step();
    b0.init_req = 1'b1;
    step();
    b0.init_req = 1'b0;
    b0.wr_en    = 1'b1;
    b0.wr_addr  = 3'd1;
    b0.wr_data  = 32'h12345678;
    b0.wr_be    = 4'hF;
    b0.rd_en    = 1'b1;
    b0.rd_addr  = 3'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_norv0", 32'(b0.rd_valid), 32'h0);
    end
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("abort_data1", b1.rd_data, 32'h0);
    chk("abort_busy1", 32'(b1.init_busy), 32'h1);
    step();
    rst = 1'b0;
    wait_clear("reclear_len");
    idle();
    for (int a = 0; a < DEP; a++) begin
      b0.rd_en   = 1'b1;
      b0.rd_addr = 3'(a);
      step();
      chk($sformatf("post_clr%0d", a), b0.rd_data, INIT);
    end
    idle();
    step();
    step();

`ifdef RAM_PARITY_EN
    u0.mem[3][0] = ~u0.mem[3][0];
    u1.mem[3][0] = ~u1.mem[3][0];
    m_mem[3][0]  = ~m_mem[3][0];
    m_bad[3]     = 1'b1;
    b0.rd_en   = 1'b1;
    b0.rd_addr = 3'd3;
    step();
    chk("par_err3", 32'(b0.parity_err), 32'h1);
    b0.rd_addr = 3'd4;
    step();
    chk("par_ok4", 32'(b0.parity_err), 32'h0);
    idle();
    step();
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_sdp_init.md
Name: ram_sdp_init

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one independent read port on a single clock. It is the successor to the single-address sync-read RAM and adds per-byte write enables, a configurable read-during-write policy and an optional output register stage with a read-valid flag. A built-in clear engine fills the array with INIT_VALUE after reset or on request, so no file preload is needed. It serves as the per-lane data store inside the cache/write-hit datapath.

Parameters:
AWIDTH, 3, address width; DEPTH = 1 << AWIDTH
DWIDTH, 32, data width; must be a multiple of 8; NBYTES = DWIDTH/8
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = write-first (new data, byte-merged)
INIT_VALUE, 0, DWIDTH-bit fill value used by the clear engine

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  AWIDTH  write address
wr_data  input  DWIDTH  write data
wr_be  input  NBYTES  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  input  1  read request
rd_addr  input  AWIDTH  read address
rd_data  output  DWIDTH  read data; holds its last value when rd_valid = 0
rd_valid  output  1  one-cycle pulse, rd_data valid
init_req  input  1  pulse starts a clear of the whole array
init_busy  output  1  clear engine active; all port requests are ignored
parity_err  output  1  parity mismatch on a read (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high. While reset = 1: rd_data = 0, rd_valid = 0, parity_err = 0, init_busy = 1, clear counter = 0, pipeline valids cleared. Array contents are not reset directly.
- Clear FSM has two states, CLEAR and READY. Reset forces CLEAR.
  - CLEAR: each cycle writes INIT_VALUE to mem[cnt] with all bytes, then cnt++. After the write of DEPTH-1 the FSM goes to READY. With cnt starting at the first clock edge after reset release, init_busy first reads 0 at the DEPTH-th edge, i.e. DEPTH cycles.
  - READY: init_req = 1 → cnt = 0 and go to CLEAR. init_req is ignored while in CLEAR.
- Reset asserted mid-clear aborts the clear; the clear restarts from address 0 after release.
- While init_busy = 1, wr_en and rd_en are ignored: no array write, no rd_valid pulse. A read accepted before the clear began still completes through the pipeline.
- Write: on a clock edge with wr_en = 1, for each i with wr_be[i] = 1, mem[wr_addr] byte i <= wr_data byte i; other bytes are unchanged. wr_be = 0 performs no write.
- Read: rd_en = 1 at edge N latches the address. rd_data and rd_valid appear after edge N+1 when OUT_REG = 0, or after edge N+2 when OUT_REG = 1. Back-to-back reads give full throughput. A read with rd_en = 0 produces no pulse.
- Same-address collision (wr_en and rd_en at the same edge, wr_addr == rd_addr):
  - RDW_MODE = 0: returns pre-write contents.
  - RDW_MODE = 1: returns wr_data for enabled bytes and old data for the others.
- Different addresses: fully independent.
- Addresses wrap naturally; there is no out-of-range address because DEPTH = 2^AWIDTH.

Optional Feature:
RAM_PARITY_EN
- Defined: each byte stores an extra even-parity bit computed at write, and the clear engine writes the parity of INIT_VALUE. On each read the parity of every byte is recomputed. parity_err pulses together with rd_valid if any byte mismatches, and it follows the same latency as rd_data.
- Undefined: no parity storage, and parity_err is tied to 0.

Decomposition:
- Shared package ram_pkg holds: the RDW_MODE encodings (RDW_OLD = 0, RDW_NEW = 1), the clear-FSM state encoding (ST_CLEAR, ST_READY), and a byte-parity function.
- One sub-module, ram_init_ctrl, holds the clear FSM, counter and init_busy, and outputs the internal clear write address, data and enable. The top level muxes the clear write against the user write port.

Test Plan:
- Reset with AWIDTH = 3, INIT_VALUE = 32'hA5A5A5A5, then wait for init_busy to go low → init_busy falls exactly 8 cycles after release; reads of addresses 0 to 7 all return A5A5A5A5.
- Write addr 2 = 32'h11223344 with be = 4'hF, then write addr 2 = 32'hFFFFFFFF with be = 4'b0101 → a read of addr 2 returns 32'h11FF33FF.
- OUT_REG = 0 versus OUT_REG = 1 with reads on consecutive cycles of addresses 0, 1, 2 → rd_valid is asserted on 3 consecutive cycles, starting 1 cycle (or 2 cycles) after the first rd_en, with data in order.
- Collision at addr 5, old = 32'h0, write 32'hDEADBEEF with be = 4'b1100 → RDW_MODE = 0 returns 0; RDW_MODE = 1 returns 32'hDEAD0000.
- Pulse init_req in READY, then issue wr_en and rd_en during CLEAR; also assert reset at cnt = 4 → requests have no effect and no rd_valid pulse appears; the clear restarts from 0 and completes 8 cycles after release.
- RAM_PARITY_EN: force-flip one stored bit at addr 3 via hierarchical deposit, then read addr 3 → parity_err = 1 together with rd_valid; other addresses give parity_err = 0.
